// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, S-box table and FSM state type for the PRESENT key schedule
package present_pkg;

    localparam int RK_W      = 64;
    localparam int KEY_W_80  = 80;
    localparam int KEY_W_128 = 128;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

endpackage

// File: rtl/present_sbox.sv
// rtl/present_sbox.sv - 4-bit combinational PRESENT S-box lookup
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] sub
);

    assign sub = SBOX[nib];

endmodule

// File: rtl/present_key_sched.sv
// rtl/present_key_sched.sv - sequential PRESENT key schedule emitting round keys over a valid/ready stream
// Optional round-key cache with random read port: define KEY_SCHED_CACHE_EN.
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_W      = 80,
    parameter int NUM_ROUNDS = 31,
    parameter int RK_W       = present_pkg::RK_W,
    parameter int CNT_W      = $clog2(NUM_ROUNDS + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_out,
    output logic [CNT_W-1:0] rk_idx,
    output logic             done
`ifdef KEY_SCHED_CACHE_EN
    ,
    input  logic [CNT_W-1:0] rd_addr,
    output logic [RK_W-1:0]  rd_data
`endif
);

    localparam int LAST    = NUM_ROUNDS + 1;
    localparam int XOR_LSB = (KEY_W == KEY_W_128) ? 62 : 15;

    generate
        if (KEY_W != KEY_W_80 && KEY_W != KEY_W_128) begin : g_bad_key_w
            $fatal(1, "present_key_sched: KEY_W must be 80 or 128");
        end
        if (RK_W != 64) begin : g_bad_rk_w
            $fatal(1, "present_key_sched: RK_W must be 64");
        end
    endgenerate

    state_t           state, state_next;
    logic [KEY_W-1:0] key_reg, key_rot, key_next;
    logic [3:0]       s_hi, s_lo;
    logic [4:0]       cnt5;
    logic             hs, last;

    assign key_rot = {key_reg[KEY_W-62:0], key_reg[KEY_W-1:KEY_W-61]};
    assign cnt5    = 5'(rk_idx);
    assign hs      = rk_valid & rk_ready;
    assign last    = (rk_idx == CNT_W'(LAST));
    assign rk_out  = key_reg[KEY_W-1 -: RK_W];

    present_sbox u_sbox_hi (.nib(key_rot[KEY_W-1 -: 4]), .sub(s_hi));

    // The 80-bit variant substitutes only the top nibble; the second nibble passes through.
    generate
        if (KEY_W == KEY_W_128) begin : g_sbox_lo
            present_sbox u_sbox_lo (.nib(key_rot[KEY_W-5 -: 4]), .sub(s_lo));
        end else begin : g_pass_lo
            assign s_lo = key_rot[KEY_W-5 -: 4];
        end
    endgenerate

    always_comb begin
        key_next                   = key_rot;
        key_next[KEY_W-1 -: 4]     = s_hi;
        key_next[KEY_W-5 -: 4]     = s_lo;
        key_next[XOR_LSB +: 5]     = key_rot[XOR_LSB +: 5] ^ cnt5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EMIT;
            EMIT:    if (hs && last) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rk_valid = (state == EMIT);
        done     = (state == FIN);
    end

    // The final key is not updated so rk_out still shows K(last) through the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
            rk_idx  <= '0;
        end else if (state == IDLE && start) begin
            key_reg <= key_in;
            rk_idx  <= CNT_W'(1);
        end else if (hs && !last) begin
            key_reg <= key_next;
            rk_idx  <= rk_idx + CNT_W'(1);
        end
    end

`ifdef KEY_SCHED_CACHE_EN
    localparam int AW = $clog2(LAST);

    logic [RK_W-1:0]  cache [LAST];
    logic [CNT_W-1:0] wr_addr;

    assign wr_addr = rk_idx - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAST; i++) begin
                cache[i] <= '0;
            end
        end else if (hs) begin
            cache[wr_addr[AW-1:0]] <= rk_out;
        end
    end

    assign rd_data = (rd_addr < CNT_W'(LAST)) ? cache[rd_addr[AW-1:0]] : '0;
`endif

endmodule

// File: tb/tb_present_key_sched.sv
// tb/tb_present_key_sched.sv - randomized self-checking bench for present_key_sched (80- and 128-bit instances)
module tb_present_key_sched;

    localparam logic [3:0] SB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start80, ready80, busy80, valid80, done80;
    logic [79:0]  key80;
    logic [63:0]  out80;
    logic [5:0]   idx80;
    logic         start128, ready128, busy128, valid128, done128;
    logic [127:0] key128;
    logic [63:0]  out128;
    logic [5:0]   idx128;
`ifdef KEY_SCHED_CACHE_EN
    logic [5:0]   rd_addr80, rd_addr128;
    logic [63:0]  rd_data80, rd_data128;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [63:0] got80 [32];
    logic [63:0] got128 [32];

    always #5 clk = ~clk;

    present_key_sched #(.KEY_W(80), .NUM_ROUNDS(31)) dut80 (
        .clk(clk), .rst(rst), .start(start80), .key_in(key80), .busy(busy80),
        .rk_valid(valid80), .rk_ready(ready80), .rk_out(out80), .rk_idx(idx80), .done(done80)
`ifdef KEY_SCHED_CACHE_EN
        , .rd_addr(rd_addr80), .rd_data(rd_data80)
`endif
    );

    present_key_sched #(.KEY_W(128), .NUM_ROUNDS(31)) dut128 (
        .clk(clk), .rst(rst), .start(start128), .key_in(key128), .busy(busy128),
        .rk_valid(valid128), .rk_ready(ready128), .rk_out(out128), .rk_idx(idx128), .done(done128)
`ifdef KEY_SCHED_CACHE_EN
        , .rd_addr(rd_addr128), .rd_data(rd_data128)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference key update written directly from the algorithm description.
    function automatic logic [127:0] model_next(input logic [127:0] k, input int kw, input int cnt);
        logic [127:0] r;
        if (kw == 80) begin
            r = {48'd0, k[79:0]};
            r = ((r << 61) | (r >> 19)) & ((128'd1 << 80) - 128'd1);
            r[79:76] = SB[r[79:76]];
            r[19:15] = r[19:15] ^ 5'(cnt);
        end else begin
            r = (k << 61) | (k >> 67);
            r[127:124] = SB[r[127:124]];
            r[123:120] = SB[r[123:120]];
            r[66:62] = r[66:62] ^ 5'(cnt);
        end
        return r;
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt);
        logic [63:0] s, t;
        s = pt;
        for (int r = 0; r < 31; r++) begin
            s = s ^ got80[r];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = SB[s[4*j +: 4]];
            t = '0;
            for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
            t[63] = s[63];
            s = t;
        end
        return s ^ got80[31];
    endfunction

    task automatic run80(input logic [79:0] key, input bit rnd, input int stall_at,
                         input int abort_at, input bit poke);
        logic [63:0]  exp_rk [32];
        logic [127:0] k;
        logic [63:0]  hold_rk;
        logic [5:0]   hold_idx;
        bit           holding;
        int           n, cyc, stalls, dones;
        k = {48'd0, key};
        for (int i = 0; i < 32; i++) begin
            exp_rk[i] = k[79:16];
            k = model_next(k, 80, i + 1);
        end
        key80 = key;
        start80 = 1'b1;
        @(posedge clk); #1;
        start80 = 1'b0;
        key80 = ~key;
        n = 1; cyc = 0; stalls = 0; holding = 0;
        while (n <= 32 && cyc < 400) begin
            cyc++;
            if (holding) begin
                check("hold_rk", out80, hold_rk);
                check("hold_idx", idx80, hold_idx);
            end
            check("emit_flags", {busy80, valid80, done80}, 3'b110);
            start80 = poke && (n == 3);
            if (n == abort_at) begin
                check("abort_idx", idx80, n);
                start80 = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("abort_flags", {busy80, valid80, done80}, 3'b000);
                check("abort_rk", out80, 64'd0);
                check("abort_idx0", idx80, 6'd0);
                dones = 0;
                repeat (40) begin
                    @(posedge clk); #1;
                    dones += int'(done80);
                end
                check("abort_no_done", dones, 0);
                return;
            end
            if (n == stall_at && stalls < 5) begin
                ready80 = 1'b0;
                stalls++;
            end else begin
                ready80 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ready80) begin
                check("rk_idx", idx80, n);
                check("rk_out", out80, exp_rk[n-1]);
                got80[n-1] = out80;
                n++;
                holding = 0;
            end else begin
                holding = 1;
                hold_rk = out80;
                hold_idx = idx80;
            end
            @(posedge clk); #1;
        end
        check("all_keys_seen", n, 33);
        if (!rnd && stall_at == 0) check("done_latency", cyc, 32);
        check("done_flags", {busy80, valid80, done80}, 3'b101);
        ready80 = 1'($urandom_range(0, 1));
        start80 = poke;
        @(posedge clk); #1;
        check("after_done", {busy80, valid80, done80}, 3'b000);
    endtask

    task automatic run128(input logic [127:0] key);
        logic [127:0] k;
        int           n;
        k = key;
        key128 = key;
        start128 = 1'b1;
        @(posedge clk); #1;
        start128 = 1'b0;
        key128 = ~key;
        ready128 = 1'b1;
        for (n = 1; n <= 32; n++) begin
            check("emit128_flags", {busy128, valid128, done128}, 3'b110);
            check("rk128_idx", idx128, n);
            check("rk128_out", out128, k[127:64]);
            got128[n-1] = out128;
            k = model_next(k, 128, n);
            @(posedge clk); #1;
        end
        check("done128_flags", {busy128, valid128, done128}, 3'b101);
        @(posedge clk); #1;
        check("after_done128", {busy128, valid128, done128}, 3'b000);
    endtask

    initial begin
        logic [79:0]  rk80;
        logic [127:0] rk128;
        rst = 1'b1;
        start80 = 1'b0; ready80 = 1'b0; key80 = '0;
        start128 = 1'b0; ready128 = 1'b0; key128 = '0;
`ifdef KEY_SCHED_CACHE_EN
        rd_addr80 = '0; rd_addr128 = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags80", {busy80, valid80, done80}, 3'b000);
        check("rst_rk80", out80, 64'd0);
        check("rst_idx80", idx80, 6'd0);
        check("rst_flags128", {busy128, valid128, done128, out128, idx128}, 0);
        rst = 1'b0;
`ifdef KEY_SCHED_CACHE_EN
        rd_addr80 = 6'(31); #1;
        check("rst_cache80", rd_data80, 64'd0);
`endif

        // All-zero key, no backpressure: known vectors and known ciphertext.
        run80(80'd0, 0, 0, 0, 0);
        check("k1_zero", got80[0], 64'h0000000000000000);
        check("k2_zero", got80[1], 64'hC000000000000000);
        check("k3_zero", got80[2], 64'h5000180000000001);
        check("cipher_zero", present_enc(64'd0), 64'h5579C1387B228445);
`ifdef KEY_SCHED_CACHE_EN
        for (int a = 0; a < 32; a++) begin
            rd_addr80 = 6'(31 - a); #1;
            check("cache80", rd_data80, got80[31-a]);
        end
`endif

        rk80 = {16'($urandom), $urandom, $urandom};
        run80(rk80, 1, 7, 0, 0);

        rk80 = {16'($urandom), $urandom, $urandom};
        run80(rk80, 0, 0, 12, 0);
        rk80 = {16'($urandom), $urandom, $urandom};
        run80(rk80, 1, 0, 0, 0);
        check("k1_after_abort", got80[0], rk80[79:16]);

        rk80 = {16'($urandom), $urandom, $urandom};
        run80(rk80, 1, 0, 0, 1);
        rk80 = {16'($urandom), $urandom, $urandom};
        run80(rk80, 0, 0, 0, 0);

        run128(128'd0);
        check("k1_128_zero", got128[0], 64'd0);
        check("k2_128_top", got128[1][63:56], 8'hCC);
`ifdef KEY_SCHED_CACHE_EN
        rd_addr128 = 6'd0; #1;
        check("cache128_a0", rd_data128, 64'd0);
        rd_addr128 = 6'd1; #1;
        check("cache128_a1", rd_data128, got128[1]);
`endif
        rk128 = {$urandom, $urandom, $urandom, $urandom};
        run128(rk128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/present_key_sched.md
# present_key_sched

Sequential, parametrised PRESENT key-schedule engine. It accepts an 80- or 128-bit master key and produces one 64-bit round key per handshake, K1 through K(NUM_ROUNDS+1), in order. It feeds the round datapath of the PRESENT encrypt core through a valid/ready stream. It replaces the single-step combinational key update with a self-sequencing block that owns its own round counter.

## Interface
- KEY_W, 80: master key width; legal values 80 or 128.
- NUM_ROUNDS, 31: number of key updates; NUM_ROUNDS+1 round keys are emitted.
- RK_W, 64: round-key width; fixed at 64.
- CNT_W, $clog2(NUM_ROUNDS+2): width of rk_idx.
- clk  input  1  clock; one clock, all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  load key_in and begin a schedule; honoured only when busy=0.
- key_in  input  KEY_W  master key; sampled on the accepted start cycle.
- busy  output  1  schedule in progress.
- rk_valid  output  1  rk_out/rk_idx valid.
- rk_ready  input  1  consumer accepts the current round key.
- rk_out  output  RK_W  current round key = key_reg[KEY_W-1 -: 64].
- rk_idx  output  CNT_W  round-key number, 1-based.
- done  output  1  one-cycle pulse after the final key is accepted.

## Operation
- FSM states:
  - IDLE: waits for start. On start, go to EMIT.
  - EMIT: advances through the schedule. On the last handshake, go to FIN.
  - FIN: lasts one cycle, then return to IDLE.
- start in IDLE: key_reg ← key_in; rk_idx ← 1.
- Handshake (rk_valid & rk_ready) in EMIT with rk_idx < NUM_ROUNDS+1: key_reg ← update(key_reg, rk_idx); rk_idx ← rk_idx+1.
- Handshake with rk_idx = NUM_ROUNDS+1: key_reg is not updated; go to FIN.
- update for KEY_W=80, applied in order:
  - rotate left by 61;
  - [79:76] ← S([79:76]);
  - [19:15] ^= counter[4:0].
- update for KEY_W=128, applied in order:
  - rotate left by 61;
  - [127:124] ← S([127:124]);
  - [123:120] ← S([123:120]);
  - [66:62] ^= counter[4:0].
- S-box, inputs 0..F: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- Counter XOR uses only the low 5 bits of rk_idx. rk_idx values above 31 wrap modulo 32 in the XOR.
- start while busy=1 is ignored.
- rk_ready while rk_valid=0 has no effect.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_out and rk_idx hold stable.

## Timing
- Reset values: busy=0, rk_valid=0, rk_out=0, rk_idx=0, done=0, FSM=IDLE. key_reg is cleared to 0.
- Reset mid-schedule: the next cycle is IDLE with all outputs at reset values. No done pulse is produced.
- Start-to-first-key latency is 1 cycle: rk_valid=1 and rk_idx=1 in the cycle after the start cycle.
- With rk_ready held high, one round key is emitted per cycle. K(NUM_ROUNDS+1) appears NUM_ROUNDS cycles after K1.
- done is high exactly in the cycle after the final handshake. In that cycle rk_valid=0 and busy=1.
- busy=0 from the cycle after done. A new start is accepted in that cycle.
- start asserted in the same cycle as done is ignored.

## Configuration
- Macro: KEY_SCHED_CACHE_EN.
- Defined:
  - Each round key is written into a (NUM_ROUNDS+1)×64 register file at address rk_idx-1 on its handshake.
  - Extra ports: rd_addr input CNT_W; rd_data output 64.
  - rd_data is combinational from the array.
  - Lets the decrypt core read keys in reverse order after done.
  - Contents survive until overwritten by the next schedule; reset clears them to 0.
  - A read of an entry not yet written in the current schedule returns stale data. This is not an error.
- Undefined: no array and no rd_* ports. Round keys are streamed only.

## Structure
- Package present_pkg holds:
  - SBOX constant array (16×4);
  - RK_W=64;
  - legal key widths KEY_W_80=80 and KEY_W_128=128;
  - FSM state enum {IDLE, EMIT, FIN}.
- Sub-module present_sbox: 4-bit combinational lookup, instantiated once for KEY_W=80 and twice for KEY_W=128.
- Elaboration check: KEY_W not in {80,128} is a fatal error.

## Test plan
- KEY_W=80, key_in=0, rk_ready=1: required keys are
  - K1=0000000000000000;
  - K2=C000000000000000;
  - K3=5000180000000001;
  - done pulses 32 cycles after start.
- KEY_W=80, key_in=0, full 32-key run: encrypting plaintext 0 with the emitted keys gives ciphertext 5579C1387B228445.
- Backpressure: hold rk_ready=0 for 5 cycles at rk_idx=7. rk_out and rk_idx must stay stable, then resume with no key skipped or repeated.
- rst asserted at rk_idx=12:
  - next cycle: all outputs at reset values and no done;
  - a fresh start then produces K1=key_in[KEY_W-1 -: 64].
- start pulsed while busy, and again in the done cycle: both are ignored; the first start after busy falls is accepted.
- KEY_SCHED_CACHE_EN, KEY_W=128, key_in=0: after done, rd_addr=0 gives 0, and rd_addr=1 gives the same value as K2 captured from the stream (top byte CC).
